// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode, forwards EX/MEM and MEM/WB results into the ALU
// operands, and raises load_use with a bubble. Optional forwarding is enabled by ID_EX_FORWARD_EN.
module id_ex_stage #(
    parameter int         XLEN       = 32,
    parameter int         RA_W       = 5,
    parameter logic [3:0] BUBBLE_SEL = 4'b0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            d_valid,
    input  logic [XLEN-1:0] d_pc,
    input  logic [XLEN-1:0] d_rs1_data,
    input  logic [XLEN-1:0] d_rs2_data,
    input  logic [XLEN-1:0] d_imm,
    input  logic [RA_W-1:0] d_rs1,
    input  logic [RA_W-1:0] d_rs2,
    input  logic [RA_W-1:0] d_rd,
    input  logic [3:0]      d_alu_sel,
    input  logic            d_sign,
    input  logic            d_shift,
    input  logic            d_use_pc,
    input  logic            d_use_imm,
    input  logic            d_reg_write,
    input  logic            d_mem_read,
    input  logic            d_mem_write,
    input  logic            stall,
    input  logic            flush,
    input  logic [RA_W-1:0] m_rd,
    input  logic            m_reg_write,
    input  logic [XLEN-1:0] m_result,
    input  logic [RA_W-1:0] w_rd,
    input  logic            w_reg_write,
    input  logic [XLEN-1:0] w_result,
    output logic [XLEN-1:0] alu_i_1,
    output logic [XLEN-1:0] alu_i_2,
    output logic [3:0]      alu_sel,
    output logic            alu_sign,
    output logic            alu_shift,
    output logic            e_valid,
    output logic [XLEN-1:0] e_pc,
    output logic [RA_W-1:0] e_rd,
    output logic            e_reg_write,
    output logic            e_mem_read,
    output logic            e_mem_write,
    output logic [XLEN-1:0] e_store_data,
    output logic            load_use
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [3:0]      alu_sel;
        logic            sign;
        logic            shift;
        logic            use_pc;
        logic            use_imm;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } ex_t;

    ex_t ex_q;
    ex_t ex_d;
    ex_t bubble;
    ex_t capture;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            e_rd_hit;

    always_comb begin
        bubble         = '0;
        bubble.alu_sel = BUBBLE_SEL;
    end

    always_comb begin
        capture.valid     = d_valid;
        capture.pc        = d_pc;
        capture.rs1_data  = d_rs1_data;
        capture.rs2_data  = d_rs2_data;
        capture.imm       = d_imm;
        capture.rs1       = d_rs1;
        capture.rs2       = d_rs2;
        capture.rd        = d_rd;
        capture.alu_sel   = d_alu_sel;
        capture.sign      = d_sign;
        capture.shift     = d_shift;
        capture.use_pc    = d_use_pc;
        capture.use_imm   = d_use_imm;
        capture.reg_write = d_reg_write;
        capture.mem_read  = d_mem_read;
        capture.mem_write = d_mem_write;
    end

    // flush beats stall; a held slot keeps load_use asserted until stall drops
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = bubble;
        end else if (stall) begin
            ex_d = ex_q;
        end else if (load_use) begin
            ex_d = bubble;
        end else begin
            ex_d = capture;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= bubble;
        end else begin
            ex_q <= ex_d;
        end
    end

    // Operand source 0 is rs1, source 1 is rs2.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic [XLEN-1:0] rf_val;
            logic [XLEN-1:0] fwd_val;

            assign rf_val = (gi == 0) ? ex_q.rs1_data : ex_q.rs2_data;
`ifdef ID_EX_FORWARD_EN
            logic [RA_W-1:0] src;

            assign src = (gi == 0) ? ex_q.rs1 : ex_q.rs2;

            // x0 never forwards; the younger EX/MEM result wins over MEM/WB
            always_comb begin
                fwd_val = rf_val;
                if (src != '0) begin
                    if (m_reg_write && (m_rd == src)) begin
                        fwd_val = m_result;
                    end else if (w_reg_write && (w_rd == src)) begin
                        fwd_val = w_result;
                    end
                end
            end
`else
            assign fwd_val = rf_val;
`endif
        end
    endgenerate

    assign fwd_rs1 = g_fwd[0].fwd_val;
    assign fwd_rs2 = g_fwd[1].fwd_val;

    assign e_rd_hit = (ex_q.rd != '0) && ((ex_q.rd == d_rs1) || (ex_q.rd == d_rs2));

`ifdef ID_EX_FORWARD_EN
    assign load_use = d_valid && ex_q.valid && ex_q.mem_read && e_rd_hit;
`else
    logic m_rd_hit;
    logic unused_nofwd;

    assign m_rd_hit = (m_rd != '0) && ((m_rd == d_rs1) || (m_rd == d_rs2));

    // Without bypasses any in-flight writer of a source register must drain;
    // MEM/WB is covered by register-file write-through.
    assign load_use = d_valid &&
                      ((ex_q.valid && ex_q.reg_write && e_rd_hit) ||
                       (m_reg_write && m_rd_hit));

    assign unused_nofwd = ^{ex_q.rs1, ex_q.rs2, m_result, w_rd, w_reg_write, w_result};
`endif

    assign alu_i_1      = ex_q.use_pc  ? ex_q.pc  : fwd_rs1;
    assign alu_i_2      = ex_q.use_imm ? ex_q.imm : fwd_rs2;
    assign e_store_data = fwd_rs2;
    assign alu_sel      = ex_q.alu_sel;
    assign alu_sign     = ex_q.sign;
    assign alu_shift    = ex_q.shift;
    assign e_valid      = ex_q.valid;
    assign e_pc         = ex_q.pc;
    assign e_rd         = ex_q.rd;
    assign e_reg_write  = ex_q.valid & ex_q.reg_write;
    assign e_mem_read   = ex_q.valid & ex_q.mem_read;
    assign e_mem_write  = ex_q.valid & ex_q.mem_write;

endmodule
